// File: rtl/ysyx_220066_div_pkg.sv
// Shared definitions for the iterative divider.
//   - op encodings (bit0 = unsigned, bit1 = remainder)
//   - FSM state type
//   - iter_count(): number of CALC iterations for a given width and radix
package ysyx_220066_div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int unsigned iter_count(input int unsigned width,
                                             input int unsigned bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/ysyx_220066_div_step.sv
// One combinational restoring-division step on a {rem, quo} shift register.
//   rem_quo_in  : current {rem[XLEN], quo[XLEN]}
//   divisor     : divisor magnitude
//   rem_quo_out : register after shifting one quotient bit in
module ysyx_220066_div_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] rem_quo_in,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] rem_quo_out
);

  // Shifted remainder needs one extra bit: an unsigned divisor may exceed 2^(XLEN-1).
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            no_borrow;

  always_comb begin
    rem_sh    = rem_quo_in[2*XLEN-1:XLEN-1];
    no_borrow = (rem_sh >= {1'b0, divisor});
    // When there is no borrow the difference is below the divisor, so XLEN bits suffice.
    diff      = rem_sh[XLEN-1:0] - divisor;
    if (no_borrow)
      rem_quo_out = {diff, rem_quo_in[XLEN-2:0], 1'b1};
    else
      rem_quo_out = {rem_sh[XLEN-1:0], rem_quo_in[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/ysyx_220066_div_iter.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per cycle.
//   clk/rst        : clock, asynchronous active-low reset
//   in_valid/in_ready, src1, src2, op, is_w : request
//   flush          : abort anything in flight
//   out_valid/out_ready, result             : response
// Divide-by-zero and signed overflow complete directly (IDLE->DONE).
// Optional: define YSYX_220066_DIV_ZERO_SKIP_EN to skip leading-zero
// iterations of the dividend (latency changes, results do not).
module ysyx_220066_div_iter
  import ysyx_220066_div_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2,
  parameter int W_SUPPORT      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      op,
  input  logic            is_w,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  div_state_e        state;
  logic [2*XLEN-1:0] rem_quo;
  logic [XLEN-1:0]   divisor;
  logic              neg_q, neg_r, is_rem, w_r;
  logic [CW-1:0]     cnt, iter_last;

  // Request decode and operand preparation
  logic              w_op, is_signed, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, most_neg, special, aligned;
  logic [2*XLEN-1:0] start;
  logic [CW-1:0]     start_last;
  int unsigned       eff_w;
`ifdef YSYX_220066_DIV_ZERO_SKIP_EN
  int unsigned       lz, skip, iters;
`endif

  always_comb begin
    w_op      = (W_SUPPORT != 0) && is_w;
    is_signed = ~op[0];
    if (w_op) begin
      a_ext = is_signed ? sext32(src1[31:0]) : XLEN'(src1[31:0]);
      b_ext = is_signed ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
    end else begin
      a_ext = src1;
      b_ext = src2;
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    most_neg = w_op ? sext32(32'h8000_0000) : (XLEN'(1) << (XLEN - 1));
    div_zero = (b_ext == '0);
    overflow = is_signed && (b_ext == '1) && (a_ext == most_neg);
    if (div_zero)
      special = op[1] ? (w_op ? sext32(a_ext[31:0]) : a_ext) : '1;
    else
      special = op[1] ? '0 : a_ext;
    eff_w = w_op ? 32 : XLEN;
    // Left-align the dividend so the quotient always lands in the low EFF_W bits.
    aligned = w_op ? (a_mag << (XLEN - 32)) : a_mag;
`ifdef YSYX_220066_DIV_ZERO_SKIP_EN
    lz = eff_w;
    for (int unsigned i = 0; i < XLEN; i++)
      if (aligned[i]) lz = XLEN - 1 - i;
    skip  = (lz / BITS_PER_CYCLE) * BITS_PER_CYCLE;
    iters = (eff_w - skip) / BITS_PER_CYCLE;
    if (iters == 0) iters = 1;
    start      = {{XLEN{1'b0}}, aligned} << skip;
    start_last = CW'(iters - 1);
`else
    start      = {{XLEN{1'b0}}, aligned};
    start_last = CW'(iter_count(eff_w, BITS_PER_CYCLE) - 1);
`endif
  end

  // Step chain: BITS_PER_CYCLE restoring steps per cycle
  logic [2*XLEN-1:0] chain [BITS_PER_CYCLE+1];
  assign chain[0] = rem_quo;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    ysyx_220066_div_step #(.XLEN(XLEN)) u_step (
      .rem_quo_in (chain[g]),
      .divisor    (divisor),
      .rem_quo_out(chain[g+1])
    );
  end

  // Sign fix-up of the final iteration's output
  logic [XLEN-1:0] q_s, r_s, sel, fixed;
  always_comb begin
    q_s   = neg_q ? -chain[BITS_PER_CYCLE][XLEN-1:0] : chain[BITS_PER_CYCLE][XLEN-1:0];
    r_s   = neg_r ? -chain[BITS_PER_CYCLE][2*XLEN-1:XLEN] : chain[BITS_PER_CYCLE][2*XLEN-1:XLEN];
    sel   = is_rem ? r_s : q_s;
    fixed = w_r ? sext32(sel[31:0]) : sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      rem_quo   <= '0;
      divisor   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_rem    <= 1'b0;
      w_r       <= 1'b0;
      cnt       <= '0;
      iter_last <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            is_rem   <= op[1];
            w_r      <= w_op;
            if (div_zero || overflow) begin
              result    <= special;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rem_quo   <= start;
              divisor   <= b_mag;
              cnt       <= '0;
              iter_last <= start_last;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          rem_quo <= chain[BITS_PER_CYCLE];
          cnt     <= cnt + CW'(1);
          if (cnt == iter_last) begin
            result    <= fixed;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_div_iter.sv
// Directed self-checking bench for ysyx_220066_div_iter (XLEN=64, R=2, W enabled).
module tb_ysyx_220066_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [1:0]  op = 2'b00;
  logic        is_w = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_220066_div_iter #(
    .XLEN          (64),
    .BITS_PER_CYCLE(2),
    .W_SUPPORT     (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src1     (src1),
    .src2     (src2),
    .op       (op),
    .is_w     (is_w),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Issue one request, wait (bounded) for the result, check latency/value, then hand it off.
  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic [1:0] o, input logic w,
                     input logic [63:0] exp, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    src1 = a; src2 = b; op = o; is_w = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    op = 2'($urandom); is_w = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_ret"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic watch_quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run("div_m7_2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run("rem_m7_2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("divu_z",    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_z",    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_z2",   64'h0123_4567_89AB_CDEF, 64'd0, 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF, 1);
    run("div_ovf",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd0, 1);
    run("divw_ovf",  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    run("divuw_1",   64'h0000_0000_FFFF_FFFF, 64'd1, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 17);
    run("remw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 17);
    run("divuw_hi",  64'h1234_5678_0000_0064, 64'hABCD_0000_0000_0007, 2'b01, 1'b1, 64'd14, 17);
    run("divu_100_7", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 33);
    run("remu_100_7", 64'd100, 64'd7, 2'b11, 1'b0, 64'd2, 33);
    run("div_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 33);
    run("rem_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 2'b10, 1'b0, 64'd2, 33);

    // Backpressure: hold out_ready low in DONE
    out_ready = 1'b0;
    src1 = 64'd100; src2 = 64'd7; op = 2'b01; is_w = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = '0; src2 = 64'd3;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_state", {result, out_valid, in_ready} == {64'd14, 1'b1, 1'b0} ? 64'd1 : 64'd0, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {62'd0, out_valid, in_ready}, 64'd1);

    // Flush mid-CALC
    src1 = 64'd1000; src2 = 64'd3; op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {62'd0, out_valid, in_ready}, 64'd1);
    watch_quiet(40, seen);
    check("flush_quiet", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC
    src1 = 64'd1000; src2 = 64'd3; op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_idle", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    watch_quiet(40, seen);
    check("arst_quiet", 64'(seen), 64'd0);

    run("post_divu", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_div_iter.md
Name: ysyx_220066_div_iter

Overview:
- Parametrised iterative restoring divider for the execute stage; the successor to the fixed 64-bit radix-2 divider.
- Retires R quotient bits per cycle, where R = BITS_PER_CYCLE.
- Handles RISC-V divide-by-zero and signed-overflow in one cycle. Sign-extends W-form results.
- Supports a flush/kill input and output backpressure via out_ready.

Parameters:
- XLEN, 64, operand/result width; 32 or 64.
- BITS_PER_CYCLE, 2, quotient bits per iteration; 1, 2 or 4; must divide XLEN.
- W_SUPPORT, 1, enables the is_w path; must be 0 when XLEN=32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- in_valid  in  1  request valid.
- in_ready  out  1  divider idle and able to accept a request.
- src1  in  XLEN  dividend.
- src2  in  XLEN  divisor.
- op  in  2  bit0=1 unsigned, bit1=1 remainder (00 div, 01 divu, 10 rem, 11 remu).
- is_w  in  1  32-bit operation on the low halves, result sign-extended.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  quotient or remainder.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0. Reset takes effect immediately when rst=0, including mid-operation.
- States are IDLE, CALC and DONE.
- Accept occurs on in_valid & in_ready, which is possible only in IDLE.
- Operand preparation on accept:
  - If is_w, operands become the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signs are latched.
  - Absolute values are loaded into a {rem[XLEN], quo[XLEN]} shift register.
  - Divisor magnitude is latched.
- Special cases on accept: result is formed directly and the state goes IDLE→DONE (out_valid in the next cycle).
  - Divisor is zero: quotient=all ones, remainder=dividend (post-W-extension).
  - Signed op with dividend=most-negative and divisor=-1 (per effective width): quotient=dividend, remainder=0.
- Normal path: IDLE→CALC.
  - Each CALC cycle performs BITS_PER_CYCLE chained restoring steps.
  - Step: trial = rem_shifted - divisor. If there is no borrow, keep trial and shift in 1; otherwise keep rem_shifted and shift in 0.
  - Iteration counter counts 0..ITER-1, where ITER = EFF_W/BITS_PER_CYCLE and EFF_W = 32 when is_w, else XLEN.
  - After the last iteration, go CALC→DONE.
  - Latency from accept to out_valid is ITER+1 cycles.
- Sign fix-up, registered into result on entry to DONE:
  - Quotient is negated if the latched signs differ.
  - Remainder takes the dividend's sign.
  - W results are sign-extended from bit 31 (including divuw/remuw).
- DONE: out_valid=1 and result is held stable until out_ready=1. On handshake, go DONE→IDLE and out_valid falls in the next cycle.
- No new accept occurs in the same cycle as the output handshake; in_ready rises one cycle later.
- flush=1 in any state: next state is IDLE, out_valid=0, and no result is delivered. flush has priority over accept and over output handshake.
- Changes to src1/src2/op/is_w after accept have no effect.

Optional Feature:
- Macro: YSYX_220066_DIV_ZERO_SKIP_EN.
- When defined:
  - On accept, count the leading zeros lz of the dividend magnitude within EFF_W.
  - Pre-shift the shift register by lz rounded down to a multiple of BITS_PER_CYCLE.
  - Reduce ITER to ceil((EFF_W-lz)/BITS_PER_CYCLE), with a minimum of 1.
  - A zero dividend completes in 1 CALC cycle.
- When undefined: ITER is always fixed at EFF_W/BITS_PER_CYCLE.
- Results are identical with and without the macro; only latency differs.

Decomposition:
- Package ysyx_220066_div_pkg contains:
  - The op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU).
  - The state typedef (IDLE/CALC/DONE).
  - A function computing ITER from width and BITS_PER_CYCLE.
- Sub-module ysyx_220066_div_step: one combinational restoring step, parametrised by XLEN, instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- XLEN=64, R=2, div src1=-7, src2=2 → result=-3, out_valid exactly 33 cycles after accept; same with op=rem → result=-1.
- divu src1=0xFFFF_FFFF_FFFF_FFFF, src2=0 → result=0xFFFF_FFFF_FFFF_FFFF one cycle after accept; remu same operands → result=src1.
- div src1=0x8000_0000_0000_0000, src2=-1 → result=0x8000_0000_0000_0000, rem → 0; is_w div 0x8000_0000 by -1 → 0xFFFF_FFFF_8000_0000.
- divuw src1=0xFFFF_FFFF, src2=1 → result=0xFFFF_FFFF_FFFF_FFFF (sign-extended), latency 17 cycles.
- Hold out_ready=0 for 10 cycles in DONE → result stable and in_ready=0; then out_ready=1 → in_ready=1 next cycle.
- flush asserted mid-CALC, then rst pulled low mid-CALC on a second request → both return to IDLE, out_valid never rises, and a following divu 100/7 → 14.
